// File: rtl/instr_sequencer.sv
// instr_sequencer: owns the PC, fetches 16-bit instructions from a synchronous
// instruction memory and issues them to control_unit, holding run high until
// cu_done. J-type instructions (jump, halt, NOP) retire here without run. A
// watchdog moves to ERR if the control unit never retires.
// Optional build macro SEQ_STEP_EN adds a step input and a STEP state that
// pauses after every retire until step is pulsed.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           pulse; begins execution at PC 0 from IDLE/HALT/ERR
//   imem_en/addr    instruction memory read request (addr = pc)
//   imem_rdata      read data, valid one cycle after imem_en
//   instr, run      instruction and advance enable for control_unit
//   cu_done         one-cycle retire pulse from control_unit
//   pc, retired     program counter, saturating retired-instruction count
//   busy/halted/error  status flags
//   step            single-step advance pulse (SEQ_STEP_EN only)
module instr_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int DONE_TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       instr,
    output logic              run,
    input  logic              cu_done,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       retired,
    output logic              busy,
    output logic              halted,
    output logic              error
`ifdef SEQ_STEP_EN
    ,
    input  logic              step
`endif
);
    localparam int WD_W = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, HALT, ERR
`ifdef SEQ_STEP_EN
        , STEP
`endif
    } state_t;

    state_t          state, nxt, after_retire;
    logic [WD_W-1:0] wd;
    logic            is_j, is_jmp, is_halt, wd_exp, retire, restart;

`ifdef SEQ_STEP_EN
    assign after_retire = STEP;
`else
    assign after_retire = FETCH;
`endif

    // Decode looks at the memory output directly; instr is loaded on the same edge.
    assign is_j    = imem_rdata[1:0] == 2'b10;
    assign is_jmp  = is_j && imem_rdata[4:2] == 3'b000;
    assign is_halt = is_j && imem_rdata[4:2] == 3'b111;
    assign wd_exp  = wd == WD_W'(DONE_TIMEOUT - 1);
    assign retire  = (state == DECODE && is_j) || (state == EXEC && cu_done);
    assign restart = start && (state == IDLE || state == HALT || state == ERR);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE, HALT, ERR: nxt = start ? FETCH : state;
            FETCH:           nxt = DECODE;
            DECODE:          nxt = is_halt ? HALT : is_j ? after_retire : EXEC;
            // cu_done takes priority over a watchdog expiry in the same cycle
            EXEC:            nxt = cu_done ? after_retire : wd_exp ? ERR : EXEC;
`ifdef SEQ_STEP_EN
            STEP:            nxt = step ? FETCH : STEP;
`endif
            default:         nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            instr   <= '0;
            retired <= '0;
            wd      <= '0;
            run     <= 1'b0;
        end else begin
            run <= nxt == EXEC;
            wd  <= state == EXEC ? wd + 1'b1 : '0;
            if (state == DECODE) instr <= imem_rdata;
            if (restart) begin
                pc      <= '0;
                retired <= '0;
            end else begin
                if (retire && retired != 16'hFFFF) retired <= retired + 1'b1;
                // halt retires but leaves pc pointing at itself
                if (state == DECODE && is_jmp) pc <= ADDR_W'(imem_rdata[12:5]);
                else if (retire && !(state == DECODE && is_halt)) pc <= pc + 1'b1;
            end
        end
    end

    assign imem_en   = state == FETCH;
    assign imem_addr = pc;
    assign busy      = state == FETCH || state == DECODE || state == EXEC;
    assign halted    = state == HALT;
    assign error     = state == ERR;
endmodule
